// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with jump, relative branch and call/return through a return-address stack
// Ports: clk, rst (async, active-high); commands inc/jmp/br/call/ret, priority inc > jmp > br > call > ret;
//        addr_in (jmp/call target), offset (signed branch offset), clr_err (clears sticky errors);
//        adout (registered PC), sp (valid stack entries), full/empty (decoded from sp),
//        ovf (call while full, sticky), unf (ret while empty, sticky).
module pc_stack_unit #(
    parameter int ADDR_W = 8,
    parameter int DEPTH = 4,
    parameter int OFF_W = 8,
    parameter int RET_OFFSET = 2,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    localparam int SP_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              jmp,
    input  logic              br,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [OFF_W-1:0]  offset,
    input  logic              clr_err,
    output logic [ADDR_W-1:0] adout,
    output logic [SP_W-1:0]   sp,
    output logic              full,
    output logic              empty,
    output logic              ovf,
    output logic              unf
);
    logic [ADDR_W-1:0] ras [DEPTH];
    logic [ADDR_W-1:0] top;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] off_ext;
    logic              do_jmp;
    logic              do_br;
    logic              do_call;
    logic              do_ret;
    logic              push;
    logic              pop;

    assign full    = sp == SP_W'(DEPTH);
    assign empty   = sp == '0;
    assign off_ext = ADDR_W'($signed(offset));
    assign do_jmp  = jmp & ~inc;
    assign do_br   = br & ~inc & ~jmp;
    assign do_call = call & ~inc & ~jmp & ~br;
    assign do_ret  = ret & ~inc & ~jmp & ~br & ~call;
    assign push    = do_call & ~full;
    assign pop     = do_ret & ~empty;

    // Top-of-stack read, entry sp-1; only consumed when sp > 0.
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++)
            top = (SP_W'(i) == sp - SP_W'(1)) ? ras[i] : top;
    end

    // A call while full or ret while empty leaves the PC untouched.
    always_comb begin
        pc_nxt = inc    ? adout + ADDR_W'(1) :
                 do_jmp ? addr_in :
                 do_br  ? adout + off_ext :
                 push   ? addr_in :
                 pop    ? top + ADDR_W'(RET_OFFSET) :
                          adout;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adout <= RESET_ADDR;
            sp    <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                ras[i] <= '0;
        end else begin
            adout <= pc_nxt;
            sp    <= push ? sp + SP_W'(1) : pop ? sp - SP_W'(1) : sp;
            // Setting an error flag takes precedence over a same-cycle clear.
            ovf   <= (do_call & full) | (ovf & ~clr_err);
            unf   <= (do_ret & empty) | (unf & ~clr_err);
            for (int i = 0; i < DEPTH; i++)
                if (push && SP_W'(i) == sp)
                    ras[i] <= adout;
        end
    end
endmodule
